dm_access_unit: RTL and testbench
=================================

// Module: dm_access_unit
// PURPOSE
//  Memory-side consumer of the decoder's 3-bit dmOp. It takes one load/store
//  request per transaction from the MEM stage and drives a word-wide data bus
//  with a request/acknowledge handshake. It generates byte enables and store-lane
//  replication, and sign/zero-extends load data. It holds the pipeline (req_ready
//  low) until the bus acknowledges or the access times out.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles without bus_ack before the access is aborted (>=2)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  req_valid  in   1   MEM stage presents an access this cycle
//  req_ready  out  1   unit idle, request accepted when req_valid&req_ready
//  req_op     in   3   dmOp: 000 LW,001 LH,010 LHU,011 LB,100 LBU,101 SW,110 SH,111 SB
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data (low byte/half used for SB/SH)
//  rsp_done   out  1   one-cycle pulse: access finished
//  rsp_rdata  out  32  extended load data, valid with rsp_done; 0 for stores/errors
//  rsp_err    out  1   with rsp_done: timeout (or misalign, see CONFIGURATION)
//  bus_req    out  1   bus request, held until bus_ack
//  bus_we     out  1   1 = write
//  bus_addr   out  32  word address {req_addr[31:2],2'b00}
//  bus_be     out  4   byte enables, bit i = byte lane i (little-endian)
//  bus_wdata  out  32  lane-replicated store data
//  bus_rdata  in   32  read data, valid with bus_ack
//  bus_ack    in   1   bus completes the access this cycle
// BEHAVIOUR
//  Reset: state IDLE. req_ready=1. rsp_done, rsp_err, bus_req, bus_we = 0.
//   rsp_rdata, bus_addr, bus_be, bus_wdata = 0. Timeout counter = 0. Reset
//   mid-access drops bus_req immediately; the access is lost without rsp_done.
//  Store = req_op in {101,110,111}; all other codes are loads.
//  FSM IDLE -> BUS -> IDLE:
//   IDLE: req_ready=1. On req_valid, register op/addr/wdata, drive bus_* and
//    bus_req=1 from the next cycle, clear the counter, go to BUS.
//   BUS: req_ready=0. bus_* stay stable. On bus_ack, drop bus_req, pulse rsp_done
//    next cycle, return to IDLE. Otherwise increment the counter. When the counter
//    reaches TIMEOUT_CYCLES-1 without ack: drop bus_req, rsp_done=1, rsp_err=1,
//    rsp_rdata=0. bus_ack in that same cycle wins; this is a normal completion.
//  Latency: accept at cycle 0, bus_req at 1, earliest ack at 1, rsp_done at 2.
//   Back-to-back accept is possible in the cycle rsp_done is high.
//  bus_ack is ignored outside BUS. req_valid is ignored while req_ready=0.
//  Byte enables: W=1111. H: addr[1]?1100:0011. B: 0001<<addr[1:0].
//  bus_wdata: SW=wdata; SH={2{wdata[15:0]}}; SB={4{wdata[7:0]}}.
//  Load extract: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend,
//   LBU/LHU zero-extend, LW passes the word. Uses the registered addr.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1,
//   issue no bus access. rsp_done=1 and rsp_err=1 one cycle after acceptance,
//   rsp_rdata=0.
//  Undefined: no check. Halfword ops ignore addr[0]; word ops ignore addr[1:0].
//   rsp_err is set only by timeout.
// TESTING
//  LW addr 0x10, ack after 3 cycles with rdata 0x8899AABB -> bus_be=1111,
//   rsp_rdata=0x8899AABB, rsp_err=0, one rsp_done pulse.
//  LB/LBU addr 0x13, rdata 0x80112233 -> be=1000; rsp_rdata 0xFFFFFF80 / 0x00000080.
//  SH addr 0x22, wdata 0x1234ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD,
//   bus_addr=0x20.
//  SB addr 0x01 with no ack, TIMEOUT_CYCLES=16 -> bus_req high 16 cycles, then
//   rsp_done=1, rsp_err=1. Repeat with ack on the 16th cycle -> rsp_err=0.
//  rst asserted while bus_req=1 -> all outputs 0 in the same cycle, no rsp_done,
//   next request served normally.
//  LW addr 0x06: with MISALIGN_TRAP_EN -> no bus_req, rsp_err=1 at cycle 1;
//   without -> bus_addr=0x04, be=1111, rsp_err=0.

Source files
------------

// File: rtl/dm_access_unit_if.sv
// Request/response and word-bus signals of dm_access_unit.
// slave = the access unit; master = the MEM stage plus the memory behind the bus.
interface dm_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, bus_rdata, bus_ack,
    input  req_ready, rsp_done, rsp_rdata, rsp_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, bus_rdata, bus_ack,
    output req_ready, rsp_done, rsp_rdata, rsp_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// Load/store access unit: byte enables, store-lane replication, load extension, ack timeout.
// Define MISALIGN_TRAP_EN to answer misaligned word/half accesses with an error and no bus cycle.
module dm_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  dm_access_unit_if.slave dm
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    OpLw  = 3'b000,
    OpLh  = 3'b001,
    OpLhu = 3'b010,
    OpLb  = 3'b011,
    OpLbu = 3'b100,
    OpSw  = 3'b101,
    OpSh  = 3'b110,
    OpSb  = 3'b111
  } dm_op_e;

  typedef enum logic {StIdle, StBus} state_e;

  function automatic logic is_store(dm_op_e op);
    return op inside {OpSw, OpSh, OpSb};
  endfunction

  function automatic logic is_word(dm_op_e op);
    return op inside {OpLw, OpSw};
  endfunction

  function automatic logic is_half(dm_op_e op);
    return op inside {OpLh, OpLhu, OpSh};
  endfunction

  function automatic logic [3:0] byte_en(dm_op_e op, logic [1:0] lo);
    if (is_word(op)) return 4'b1111;
    if (is_half(op)) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b0001 << lo;
  endfunction

  function automatic logic [31:0] store_data(dm_op_e op, logic [31:0] wd);
    if (is_word(op)) return wd;
    if (is_half(op)) return {2{wd[15:0]}};
    return {4{wd[7:0]}};
  endfunction

  function automatic logic [31:0] load_data(dm_op_e op, logic [1:0] lo, logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (op)
      OpLw:    return rd;
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'h0000, h};
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'h000000, b};
      default: return 32'h0000_0000;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(dm_op_e op, logic [1:0] lo);
    return (is_word(op) && (lo != 2'b00)) || (is_half(op) && lo[0]);
  endfunction
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  dm_op_e          op_q, op_d;
  logic [1:0]      lo_q, lo_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic            rsp_done_q, rsp_done_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  dm_op_e          req_op;
  logic            trap;

  assign req_op = dm_op_e'(dm.req_op);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lo_d        = lo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_done_d  = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
    trap = misaligned(req_op, dm.req_addr[1:0]);
`else
    trap = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (dm.req_valid) begin
          op_d  = req_op;
          lo_d  = dm.req_addr[1:0];
          cnt_d = '0;
          if (trap) begin
            // Completes straight from idle; the bus never sees the access.
            rsp_done_d = 1'b1;
            rsp_err_d  = 1'b1;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = is_store(req_op);
            bus_addr_d  = {dm.req_addr[31:2], 2'b00};
            bus_be_d    = byte_en(req_op, dm.req_addr[1:0]);
            bus_wdata_d = store_data(req_op, dm.req_wdata);
            state_d     = StBus;
          end
        end
      end
      StBus: begin
        // An ack in the final timeout cycle still counts as a normal completion.
        if (dm.bus_ack) begin
          bus_req_d   = 1'b0;
          rsp_done_d  = 1'b1;
          rsp_rdata_d = load_data(op_q, lo_q, dm.bus_rdata);
          state_d     = StIdle;
        end else if (cnt_q == CntLast) begin
          bus_req_d  = 1'b0;
          rsp_done_d = 1'b1;
          rsp_err_d  = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= OpLw;
      lo_q        <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      rsp_done_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_done_q  <= rsp_done_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign dm.req_ready = (state_q == StIdle);
  assign dm.rsp_done  = rsp_done_q;
  assign dm.rsp_err   = rsp_err_q;
  assign dm.rsp_rdata = rsp_rdata_q;
  assign dm.bus_req   = bus_req_q;
  assign dm.bus_we    = bus_we_q;
  assign dm.bus_addr  = bus_addr_q;
  assign dm.bus_be    = bus_be_q;
  assign dm.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed cases plus random accesses against a byte-lane model.
// Honours MISALIGN_TRAP_EN when the build defines it.
module tb_dm_access_unit;
  localparam int unsigned TimeoutCycles = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  dm_access_unit_if dm_if ();

  dm_access_unit #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk (clk),
    .rst (rst),
    .dm  (dm_if)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes, naturally aligned lane, extension rules.
  function automatic int unsigned op_size(logic [2:0] op);
    case (op)
      3'd0, 3'd5:       return 4;
      3'd1, 3'd2, 3'd6: return 2;
      default:          return 1;
    endcase
  endfunction

  function automatic bit op_store(logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic bit op_signed(logic [2:0] op);
    return (op == 3'd1) || (op == 3'd3);
  endfunction

  function automatic int unsigned lane_of(logic [2:0] op, logic [31:0] addr);
    int unsigned sz = op_size(op);
    return ((addr % 4) / sz) * sz;
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] op, logic [31:0] addr);
    return 4'(((32'd1 << op_size(op)) - 1) << lane_of(op, addr));
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] op, logic [31:0] wdata);
    int unsigned sz = op_size(op);
    logic [31:0] unit_v, r;
    unit_v = (sz == 4) ? wdata : (wdata & ((32'd1 << (8 * sz)) - 1));
    r = 32'h0;
    for (int k = 0; k < 4; k += int'(sz)) r = r | (unit_v << (8 * k));
    return r;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] op, logic [31:0] addr, logic [31:0] rd);
    int unsigned sz = op_size(op);
    logic [31:0] v, mask;
    if (op_store(op)) return 32'h0;
    v = rd >> (8 * lane_of(op, addr));
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 1;
    v = v & mask;
    if (op_signed(op) && (((v >> (8 * sz - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  function automatic bit model_trap(logic [2:0] op, logic [31:0] addr);
    bit en = 1'b0;
`ifdef MISALIGN_TRAP_EN
    en = 1'b1;
`endif
    return en && (((addr % 4) % op_size(op)) != 0);
  endfunction

  // Drives one access (starting just after a rising edge with the unit idle) and records what
  // the bus and response side did over cycles 1..exp_done+1. ack_at=0 means never acknowledge.
  task automatic run_access(
    input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
    input int ack_at, input logic [31:0] rdata, input int exp_done, input bit noise,
    output bit ready0, output int req_cycles, output int done_cycle, output int done_count,
    output bit stable, output logic we, output logic [31:0] baddr, output logic [3:0] be,
    output logic [31:0] bwdata, output logic err, output logic [31:0] rsp);
    req_cycles = 0; done_cycle = -1; done_count = 0; stable = 1'b1;
    we = 1'b0; baddr = 32'h0; be = 4'h0; bwdata = 32'h0; err = 1'b0; rsp = 32'h0;
    dm_if.req_valid = 1'b1; dm_if.req_op = op; dm_if.req_addr = addr; dm_if.req_wdata = wdata;
    dm_if.bus_ack = noise; dm_if.bus_rdata = $urandom;
    @(negedge clk);
    ready0 = dm_if.req_ready;
    @(posedge clk); #1;
    for (int c = 1; c <= exp_done + 1; c++) begin
      dm_if.req_valid = noise && (c < exp_done) && ($urandom_range(0, 1) == 1);
      dm_if.req_op = 3'($urandom); dm_if.req_addr = $urandom; dm_if.req_wdata = $urandom;
      dm_if.bus_ack = (c == ack_at) || (noise && (c == exp_done));
      dm_if.bus_rdata = (c == ack_at) ? rdata : $urandom;
      @(negedge clk);
      if (dm_if.bus_req) begin
        if (req_cycles == 0) begin
          we = dm_if.bus_we; baddr = dm_if.bus_addr; be = dm_if.bus_be; bwdata = dm_if.bus_wdata;
        end else if ({we, baddr, be, bwdata} !==
                     {dm_if.bus_we, dm_if.bus_addr, dm_if.bus_be, dm_if.bus_wdata}) begin
          stable = 1'b0;
        end
        req_cycles++;
      end
      if (dm_if.rsp_done) begin
        if (done_count == 0) begin
          done_cycle = c; err = dm_if.rsp_err; rsp = dm_if.rsp_rdata;
        end
        done_count++;
      end
      @(posedge clk); #1;
    end
    dm_if.req_valid = 1'b0; dm_if.bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dm_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", dm_if.req_ready);
    end
    checks++;
    if ({dm_if.rsp_done, dm_if.rsp_err, dm_if.bus_req, dm_if.bus_we, dm_if.rsp_rdata,
         dm_if.bus_addr, dm_if.bus_be, dm_if.bus_wdata} !== 104'h0) begin
      failures++;
      $display("FAIL reset_outputs got done=%b err=%b req=%b we=%b rdata=%h addr=%h be=%b wd=%h exp all 0",
               dm_if.rsp_done, dm_if.rsp_err, dm_if.bus_req, dm_if.bus_we, dm_if.rsp_rdata,
               dm_if.bus_addr, dm_if.bus_be, dm_if.bus_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dm_if.req_ready, dm_if.bus_req, dm_if.rsp_done} !== 3'b100) begin
      failures++;
      $display("FAIL post_reset_idle got ready/req/done=%b exp=100",
               {dm_if.req_ready, dm_if.bus_req, dm_if.rsp_done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    bit r0, st; int nreq, dc, dn; logic we, err; logic [31:0] ba, bw, rsp; logic [3:0] be;
    run_access(3'd0, 32'h10, 32'h0, 3, 32'h8899AABB, 4, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    checks++;
    if (r0 !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", r0); end
    checks++;
    if (be !== 4'b1111) begin failures++; $display("FAIL lw_be got=%b exp=1111", be); end
    checks++;
    if (rsp !== 32'h8899AABB) begin failures++; $display("FAIL lw_rdata got=%h exp=8899aabb", rsp); end
    checks++;
    if ({err, we} !== 2'b00) begin failures++; $display("FAIL lw_err_we got=%b exp=00", {err, we}); end
    checks++;
    if (dn !== 1 || dc !== 4 || nreq !== 3) begin
      failures++; $display("FAIL lw_timing got pulses=%0d done=%0d req=%0d exp 1/4/3", dn, dc, nreq);
    end

    run_access(3'd3, 32'h13, 32'h0, 1, 32'h80112233, 2, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    checks++;
    if (be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", be); end
    checks++;
    if (rsp !== 32'hFFFFFF80 || dc !== 2) begin
      failures++; $display("FAIL lb_rdata got=%h at %0d exp=ffffff80 at 2", rsp, dc);
    end

    run_access(3'd4, 32'h13, 32'h0, 2, 32'h80112233, 3, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    checks++;
    if (rsp !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", rsp); end

    run_access(3'd6, 32'h22, 32'h1234ABCD, 2, 32'hDEADBEEF, 3, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    checks++;
    if ({we, be} !== 5'b11100) begin failures++; $display("FAIL sh_we_be got=%b exp=11100", {we, be}); end
    checks++;
    if (bw !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", bw); end
    checks++;
    if (ba !== 32'h20) begin failures++; $display("FAIL sh_addr got=%h exp=00000020", ba); end
    checks++;
    if (rsp !== 32'h0 || err !== 1'b0) begin
      failures++; $display("FAIL sh_rsp got rdata=%h err=%b exp 0/0", rsp, err);
    end
  endtask

  task automatic test_timeout();
    bit r0, st; int nreq, dc, dn; logic we, err; logic [31:0] ba, bw, rsp; logic [3:0] be;
    run_access(3'd7, 32'h01, 32'h55, 0, 32'h0, TimeoutCycles + 1, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    checks++;
    if (nreq !== TimeoutCycles) begin failures++; $display("FAIL to_req_cycles got=%0d exp=16", nreq); end
    checks++;
    if (dc !== TimeoutCycles + 1 || dn !== 1) begin
      failures++; $display("FAIL to_done got cycle=%0d pulses=%0d exp 17/1", dc, dn);
    end
    checks++;
    if (err !== 1'b1 || rsp !== 32'h0) begin
      failures++; $display("FAIL to_err got err=%b rdata=%h exp 1/0", err, rsp);
    end
    run_access(3'd7, 32'h01, 32'h55, TimeoutCycles, 32'h0, TimeoutCycles + 1, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    checks++;
    if (err !== 1'b0 || dc !== TimeoutCycles + 1 || nreq !== TimeoutCycles) begin
      failures++; $display("FAIL late_ack got err=%b done=%0d req=%0d exp 0/17/16", err, dc, nreq);
    end
  endtask

  task automatic test_misalign();
    bit r0, st; int nreq, dc, dn; logic we, err; logic [31:0] ba, bw, rsp; logic [3:0] be;
    bit trap_en = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_en = 1'b1;
`endif
    run_access(3'd0, 32'h06, 32'h0, 1, 32'hCAFEF00D, trap_en ? 1 : 2, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    if (trap_en) begin
      checks++;
      if (nreq !== 0 || dc !== 1 || err !== 1'b1 || rsp !== 32'h0) begin
        failures++;
        $display("FAIL misalign_trap got req=%0d done=%0d err=%b rdata=%h exp 0/1/1/0",
                 nreq, dc, err, rsp);
      end
    end else begin
      checks++;
      if (ba !== 32'h04 || be !== 4'b1111) begin
        failures++; $display("FAIL misalign_addr got addr=%h be=%b exp 00000004/1111", ba, be);
      end
      checks++;
      if (err !== 1'b0 || rsp !== 32'hCAFEF00D || dc !== 2) begin
        failures++;
        $display("FAIL misalign_rsp got err=%b rdata=%h done=%0d exp 0/cafef00d/2", err, rsp, dc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1 = $urandom;
    logic [31:0] r2 = $urandom;
    dm_if.req_valid = 1'b1; dm_if.req_op = 3'd0; dm_if.req_addr = 32'h100;
    @(posedge clk); #1;
    dm_if.req_valid = 1'b0; dm_if.bus_ack = 1'b1; dm_if.bus_rdata = r1;
    @(negedge clk);
    checks++;
    if (dm_if.bus_req !== 1'b1 || dm_if.bus_addr !== 32'h100) begin
      failures++; $display("FAIL b2b_first_req got req=%b addr=%h exp 1/00000100",
                           dm_if.bus_req, dm_if.bus_addr);
    end
    @(posedge clk); #1;
    dm_if.bus_ack = 1'b0;
    dm_if.req_valid = 1'b1; dm_if.req_op = 3'd4; dm_if.req_addr = 32'h205;
    @(negedge clk);
    checks++;
    if ({dm_if.rsp_done, dm_if.req_ready} !== 2'b11 || dm_if.rsp_rdata !== model_load(3'd0, 32'h100, r1)) begin
      failures++; $display("FAIL b2b_first_done got done/ready=%b rdata=%h exp 11/%h",
                           {dm_if.rsp_done, dm_if.req_ready}, dm_if.rsp_rdata, r1);
    end
    @(posedge clk); #1;
    dm_if.req_valid = 1'b0; dm_if.bus_ack = 1'b1; dm_if.bus_rdata = r2;
    @(negedge clk);
    checks++;
    if ({dm_if.bus_req, dm_if.rsp_done, dm_if.bus_addr, dm_if.bus_be} !==
        {2'b10, 32'h204, model_be(3'd4, 32'h205)}) begin
      failures++; $display("FAIL b2b_second_req got req=%b done=%b addr=%h be=%b exp 1/0/00000204/%b",
                           dm_if.bus_req, dm_if.rsp_done, dm_if.bus_addr, dm_if.bus_be,
                           model_be(3'd4, 32'h205));
    end
    @(posedge clk); #1;
    dm_if.bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_if.rsp_done !== 1'b1 || dm_if.rsp_rdata !== model_load(3'd4, 32'h205, r2)) begin
      failures++; $display("FAIL b2b_second_done got done=%b rdata=%h exp 1/%h",
                           dm_if.rsp_done, dm_if.rsp_rdata, model_load(3'd4, 32'h205, r2));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    bit r0, st, seen; int nreq, dc, dn; logic we, err; logic [31:0] ba, bw, rsp; logic [3:0] be;
    dm_if.req_valid = 1'b1; dm_if.req_op = 3'd5; dm_if.req_addr = 32'h40; dm_if.req_wdata = 32'h1;
    @(posedge clk); #1;
    dm_if.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dm_if.bus_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got req=%b exp=1", dm_if.bus_req); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dm_if.rsp_done, dm_if.rsp_err, dm_if.bus_req, dm_if.bus_we, dm_if.rsp_rdata,
         dm_if.bus_addr, dm_if.bus_be, dm_if.bus_wdata} !== 104'h0 || dm_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_outputs got req=%b we=%b addr=%h be=%b ready=%b exp 0/0/0/0/1",
                           dm_if.bus_req, dm_if.bus_we, dm_if.bus_addr, dm_if.bus_be, dm_if.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; dm_if.bus_ack = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dm_if.rsp_done || dm_if.bus_req) seen = 1'b1;
      @(posedge clk); #1;
    end
    dm_if.bus_ack = 1'b0;
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_lost got activity=%b exp=0", seen); end
    run_access(3'd5, 32'h44, 32'h600DCAFE, 2, 32'h0, 3, 1'b0,
               r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
    checks++;
    if ({we, ba, be, bw} !== {1'b1, 32'h44, 4'b1111, 32'h600DCAFE} || dc !== 3 || err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_next got we=%b addr=%h be=%b wd=%h done=%0d err=%b exp 1/44/1111/600dcafe/3/0",
                           we, ba, be, bw, dc, err);
    end
  endtask

  task automatic test_random();
    bit r0, st, trap; int nreq, dc, dn, ack_at, exp_done, exp_req;
    logic we, err, exp_err; logic [31:0] ba, bw, rsp, exp_rsp; logic [3:0] be;
    logic [2:0] op; logic [31:0] addr, wdata, rdata;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom); addr = $urandom; wdata = $urandom; rdata = $urandom;
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      trap = model_trap(op, addr);
      if (trap) begin
        exp_done = 1; exp_req = 0; exp_err = 1'b1; exp_rsp = 32'h0;
      end else if (ack_at == 0) begin
        exp_done = TimeoutCycles + 1; exp_req = TimeoutCycles; exp_err = 1'b1; exp_rsp = 32'h0;
      end else begin
        exp_done = ack_at + 1; exp_req = ack_at; exp_err = 1'b0; exp_rsp = model_load(op, addr, rdata);
      end
      run_access(op, addr, wdata, ack_at, rdata, exp_done, 1'b1,
                 r0, nreq, dc, dn, st, we, ba, be, bw, err, rsp);
      checks++;
      if (dc !== exp_done || dn !== 1 || nreq !== exp_req) begin
        failures++; $display("FAIL rnd%0d_timing op=%0d got done=%0d pulses=%0d req=%0d exp %0d/1/%0d",
                             n, op, dc, dn, nreq, exp_done, exp_req);
      end
      checks++;
      if (err !== exp_err || rsp !== exp_rsp) begin
        failures++; $display("FAIL rnd%0d_rsp op=%0d addr=%h got err=%b rdata=%h exp %b/%h",
                             n, op, addr, err, rsp, exp_err, exp_rsp);
      end
      if (!trap) begin
        checks++;
        if ({we, ba, be} !== {op_store(op), addr & 32'hFFFF_FFFC, model_be(op, addr)}) begin
          failures++; $display("FAIL rnd%0d_bus op=%0d got we=%b addr=%h be=%b exp %b/%h/%b", n, op,
                               we, ba, be, op_store(op), addr & 32'hFFFF_FFFC, model_be(op, addr));
        end
        checks++;
        if (op_store(op) && bw !== model_wdata(op, wdata)) begin
          failures++; $display("FAIL rnd%0d_wdata op=%0d got=%h exp=%h", n, op, bw, model_wdata(op, wdata));
        end
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL rnd%0d_stable got=%b exp=1", n, st); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    dm_if.req_valid = 1'b0; dm_if.req_op = 3'd0; dm_if.req_addr = 32'h0; dm_if.req_wdata = 32'h0;
    dm_if.bus_ack = 1'b0; dm_if.bus_rdata = 32'h0;
    test_reset();
    test_directed();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
